gg_cordic_vec: RTL and testbench

Givens-generation (GG) boundary cell of the CORDIC QR systolic array. It sits directly upstream of the row of GR cells.
- Holds the diagonal element r and vectors (r, a_in) so that a_in is annihilated.
- Emits the micro-rotation direction bits, 4 per cycle, so downstream GR cells replay the same rotation on their elements.
- After N_ROT rotations it flags the final r as valid.

---
 rtl/gg_cordic_vec.sv | 187 ++++++++++++++++++
 tb/tb_gg_cordic_vec.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gg_cordic_vec.sv
// Givens-generation boundary cell for a CORDIC QR array: vectors (r, a_in) to annihilate a_in,
// streams micro-rotation directions to the GR row, and rescales r once per rotation.
module gg_cordic_vec #(
  parameter int                    D_WIDTH    = 4,
  parameter int                    DATA_WIDTH = 20,
  parameter int                    FRAC_BITS  = 10,
  parameter int                    N_ROT      = 2,
  parameter logic [DATA_WIDTH-1:0] K          = 20'd621
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] a_in,
  output logic                  busy_o,
  output logic [D_WIDTH-1:0]    d_o,
  output logic                  rotates_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] r_ff_o,
  output logic                  r_valid_o
);

  localparam int SHW = $clog2(3 * D_WIDTH) + 1;
  localparam int RCW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              cnt_reg, cnt_next;
  logic [RCW-1:0]          rot_cnt_reg;
  logic signed [DATA_WIDTH-1:0] x_reg, y_reg;

  logic                    start;
  logic                    iter_en;
  logic                    scale_en;

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------- next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (clr_i) begin
      state_next = IDLE;
      cnt_next   = 2'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i) begin
            state_next = ITER;
            cnt_next   = 2'd1;
          end
        end
        ITER: begin
          if (cnt_reg == 2'd3) begin
            state_next = IDLE;
            cnt_next   = 2'd0;
          end else begin
            cnt_next = cnt_reg + 2'd1;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 2'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- output / control decode
  always_comb begin
    start    = 1'b0;
    iter_en  = 1'b0;
    scale_en = 1'b0;
    busy_o   = 1'b0;
    case (state_reg)
      IDLE: begin
        start   = valid_i & ~clr_i;
        iter_en = start;
        busy_o  = start;
      end
      ITER: begin
        busy_o   = 1'b1;
        iter_en  = (cnt_reg != 2'd3);
        scale_en = (cnt_reg == 2'd3);
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------- vectoring chain
  // The first group starts from the stored r and the fresh a_in; later groups continue from x/y.
  logic signed [DATA_WIDTH-1:0] xc [0:D_WIDTH];
  logic signed [DATA_WIDTH-1:0] yc [0:D_WIDTH];
  logic [D_WIDTH-1:0]           dv;

  assign xc[0] = (state_reg == ITER) ? x_reg : $signed(r_ff_o);
  assign yc[0] = (state_reg == ITER) ? y_reg : $signed(a_in);

  genvar gi;
  generate
    for (gi = 0; gi < D_WIDTH; gi++) begin : g_stage
      logic [SHW-1:0]               sh;
      logic signed [DATA_WIDTH-1:0] xs;
      logic signed [DATA_WIDTH-1:0] ys;

      assign sh = SHW'(int'(cnt_reg) * D_WIDTH + gi);
      assign xs = xc[gi] >>> sh;
      assign ys = yc[gi] >>> sh;
      // Negative y rotates counter-clockwise; y == 0 counts as non-negative.
      assign dv[gi]    = yc[gi][DATA_WIDTH-1];
      assign xc[gi+1]  = dv[gi] ? (xc[gi] - ys) : (xc[gi] + ys);
      assign yc[gi+1]  = dv[gi] ? (yc[gi] + xs) : (yc[gi] - xs);
    end
  endgenerate

  // ---------------------------------------------------------------- gain compensation
  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   r_scaled;
  logic                    unused_product_bits;

  assign product  = {{DATA_WIDTH{x_reg[DATA_WIDTH-1]}}, x_reg} * {{DATA_WIDTH{1'b0}}, K};
  assign r_scaled = {product[2*DATA_WIDTH-1], product[DATA_WIDTH+FRAC_BITS-2:FRAC_BITS]};
  assign unused_product_bits = ^{product[2*DATA_WIDTH-2:DATA_WIDTH+FRAC_BITS-1],
                                 product[FRAC_BITS-1:0]};

  // ---------------------------------------------------------------- datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg       <= '0;
      y_reg       <= '0;
      d_o         <= '0;
      rotates_o   <= 1'b0;
      valid_o     <= 1'b0;
      r_valid_o   <= 1'b0;
      r_ff_o      <= '0;
      rot_cnt_reg <= '0;
    end else if (clr_i) begin
      x_reg       <= '0;
      y_reg       <= '0;
      d_o         <= '0;
      rotates_o   <= 1'b0;
      valid_o     <= 1'b0;
      r_valid_o   <= 1'b0;
      rot_cnt_reg <= '0;
      // r survives a clear unless nothing is accumulated or in flight.
      if (rot_cnt_reg == '0 && state_reg == IDLE) begin
        r_ff_o <= '0;
      end
    end else begin
      rotates_o <= 1'b0;
      valid_o   <= 1'b0;
      r_valid_o <= 1'b0;
      if (iter_en) begin
        d_o       <= dv;
        rotates_o <= 1'b1;
        valid_o   <= start;
        x_reg     <= xc[D_WIDTH];
        y_reg     <= yc[D_WIDTH];
      end
      if (scale_en) begin
        r_ff_o <= r_scaled;
        if (rot_cnt_reg == RCW'(N_ROT - 1)) begin
          rot_cnt_reg <= '0;
          r_valid_o   <= 1'b1;
        end else begin
          rot_cnt_reg <= rot_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gg_cordic_vec.sv
// Directed bench for gg_cordic_vec: hand-derived direction groups and rescaled r values
// for several rotations, plus busy gating, clear and asynchronous reset behaviour.
module tb_gg_cordic_vec;

  localparam int DW = 20;

  logic          clk;
  logic          rst_n;
  logic          clr_i;
  logic          valid_i;
  logic [DW-1:0] a_in;
  logic          busy_o;
  logic [3:0]    d_o;
  logic          rotates_o;
  logic          valid_o;
  logic [DW-1:0] r_ff_o;
  logic          r_valid_o;

  int tests_run;
  int tests_failed;
  int pulses;

  gg_cordic_vec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (clr_i),
    .valid_i   (valid_i),
    .a_in      (a_in),
    .busy_o    (busy_o),
    .d_o       (d_o),
    .rotates_o (rotates_o),
    .valid_o   (valid_o),
    .r_ff_o    (r_ff_o),
    .r_valid_o (r_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    a_in    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; issues a_in in that cycle (T) and ends at the negedge of T+4.
  task automatic rotate(input string tag, input logic [DW-1:0] a, input bit full,
                        input logic [3:0] g0, input logic [3:0] g1, input logic [3:0] g2,
                        input int r, input int rv);
    valid_i = 1'b1;
    a_in    = a;
    #1;
    check_eq({tag, " busy@T"}, int'(busy_o), 1);
    @(negedge clk);
    valid_i = 1'b0;
    check_eq({tag, " valid@T+1"}, int'(valid_o), 1);
    check_eq({tag, " rot@T+1"}, int'(rotates_o), 1);
    if (full) check_eq({tag, " g0"}, int'(d_o), int'(g0));
    @(negedge clk);
    check_eq({tag, " valid@T+2"}, int'(valid_o), 0);
    if (full) check_eq({tag, " g1"}, int'(d_o), int'(g1));
    @(negedge clk);
    check_eq({tag, " rot@T+3"}, int'(rotates_o), 1);
    check_eq({tag, " busy@T+3"}, int'(busy_o), 1);
    if (full) check_eq({tag, " g2"}, int'(d_o), int'(g2));
    @(negedge clk);
    check_eq({tag, " busy@T+4"}, int'(busy_o), 0);
    check_eq({tag, " rot@T+4"}, int'(rotates_o), 0);
    check_eq({tag, " rvalid@T+4"}, int'(r_valid_o), rv);
    if (full) begin
      check_eq({tag, " r@T+4"}, int'(r_ff_o), r);
      check_eq({tag, " dhold@T+4"}, int'(d_o), int'(g2));
    end
    $display("[TB] %s a_in=%0d d=%b r=%0d r_valid=%0b", tag, $signed(a), d_o, r_ff_o, r_valid_o);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    do_reset();
    check_eq("rst busy", int'(busy_o), 0);
    check_eq("rst d", int'(d_o), 0);
    check_eq("rst rot", int'(rotates_o), 0);
    check_eq("rst valid", int'(valid_o), 0);
    check_eq("rst r", int'(r_ff_o), 0);
    check_eq("rst rvalid", int'(r_valid_o), 0);

    // r = 0, a = +1.0 and -1.0: the direction streams are bitwise inverses.
    rotate("s1", 20'd1024, 1'b1, 4'b0000, 4'b1101, 4'b0000, 1023, 0);
    do_reset();
    rotate("s2", -20'sd1024, 1'b1, 4'b1111, 4'b0010, 4'b1111, 1024, 0);

    // Two chained rotations: r_valid only after the second, then a single-cycle pulse.
    do_reset();
    rotate("s3a", 20'd768, 1'b1, 4'b0000, 4'b1101, 4'b0000, 767, 0);
    rotate("s3b", 20'd1024, 1'b1, 4'b1100, 4'b0010, 4'b0111, 1278, 1);
    @(negedge clk);
    check_eq("s3 rvalid pulse", int'(r_valid_o), 0);

    // Requests while busy are ignored; the T+4 request starts the next rotation.
    do_reset();
    pulses  = 0;
    valid_i = 1'b1;
    a_in    = 20'd1024;
    @(negedge clk);
    a_in = -20'sd1024;
    pulses += int'(valid_o);
    check_eq("s4 g0", int'(d_o), 4'b0000);
    @(negedge clk);
    pulses += int'(valid_o);
    check_eq("s4 g1", int'(d_o), 4'b1101);
    valid_i = 1'b0;
    @(negedge clk);
    pulses += int'(valid_o);
    check_eq("s4 g2", int'(d_o), 4'b0000);
    @(negedge clk);
    pulses += int'(valid_o);
    check_eq("s4 one pulse", pulses, 1);
    check_eq("s4 r", int'(r_ff_o), 1023);
    valid_i = 1'b1;
    a_in    = 20'd0;
    @(negedge clk);
    valid_i = 1'b0;
    check_eq("s4 restart valid@T+5", int'(valid_o), 1);
    repeat (3) @(negedge clk);
    check_eq("s4 rvalid@T+8", int'(r_valid_o), 1);
    $display("[TB] s4 busy gating pulses=%0d", pulses);

    // Clear mid-rotation keeps r; clear when idle with no count pending zeroes r.
    do_reset();
    rotate("s5a", 20'd1024, 1'b1, 4'b0000, 4'b1101, 4'b0000, 1023, 0);
    valid_i = 1'b1;
    a_in    = 20'd512;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    check_eq("s5 rot after clr", int'(rotates_o), 0);
    check_eq("s5 d after clr", int'(d_o), 0);
    check_eq("s5 busy after clr", int'(busy_o), 0);
    check_eq("s5 r held", int'(r_ff_o), 1023);
    clr_i   = 1'b1;
    valid_i = 1'b1;
    a_in    = 20'd256;
    #1;
    check_eq("s5 clr+valid busy", int'(busy_o), 0);
    @(negedge clk);
    clr_i   = 1'b0;
    valid_i = 1'b0;
    check_eq("s5 clr+valid dropped", int'(valid_o), 0);
    check_eq("s5 idle clr r", int'(r_ff_o), 0);
    $display("[TB] s5 clear r=%0d", r_ff_o);
    rotate("s5b", 20'd1024, 1'b1, 4'b0000, 4'b1101, 4'b0000, 1023, 0);
    rotate("s5c", 20'd0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 1);

    // Asynchronous reset in the middle of a rotation.
    rotate("s6pre", 20'd1024, 1'b0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    valid_i = 1'b1;
    a_in    = 20'd1024;
    @(negedge clk);
    valid_i = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("s6 async rot", int'(rotates_o), 0);
    check_eq("s6 async d", int'(d_o), 0);
    check_eq("s6 async busy", int'(busy_o), 0);
    check_eq("s6 async r", int'(r_ff_o), 0);
    $display("[TB] s6 async reset r=%0d d=%b", r_ff_o, d_o);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rotate("s6", 20'd512, 1'b1, 4'b0000, 4'b1101, 4'b0000, 512, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
